// File: rtl/spi_register_master.sv
// SPI mode-0 initiator for the register protocol: 8-bit command, then 32-bit word.
// Host-side stand-in for loopback self-test and register-file stimulus.
module spi_register_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_write,
  input  logic [6:0]  reg_addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        sck,
  output logic        cs_n,
  output logic        sdo,
  input  logic        sdi
);
  localparam int CMAX =
    (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CMAX);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CMD_SHIFT,
    GAP,
    DATA_SHIFT,
    CS_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          phase;
  logic [4:0]    bcnt;
  logic [39:0]   tx_sr;
  logic [31:0]   rx_sr;
  logic          wr_q;

  logic shifting;
  logic half_end;
  logic gap_end;
  logic bit_end;
  logic last_bit;

  assign shifting = (state == CMD_SHIFT) ||
                    (state == DATA_SHIFT);
  assign half_end = (cnt == CW'(CLK_DIV - 1));
  assign gap_end  = (cnt == CW'(GAP_CYCLES - 1));
  assign bit_end  = shifting && phase && half_end;
  assign last_bit = (bcnt == 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = CS_SETUP;
      CS_SETUP:   if (half_end) state_nxt = CMD_SHIFT;
      CMD_SHIFT:  if (bit_end && last_bit) state_nxt = GAP;
      GAP:        if (gap_end) state_nxt = DATA_SHIFT;
      DATA_SHIFT: if (bit_end && last_bit) state_nxt = CS_HOLD;
      CS_HOLD:    if (half_end) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    cs_n = (state == IDLE);
    sck  = shifting && phase;
    sdo  = (state != IDLE) && tx_sr[39];
  end

  // tx_sr shifts at the end of each high phase, so sdo
  // only moves at the start of a low phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
      bcnt  <= 5'd0;
      tx_sr <= '0;
      rx_sr <= '0;
      wr_q  <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        cnt   <= '0;
        phase <= 1'b0;
        if (start) begin
          wr_q  <= is_write;
          bcnt  <= 5'd7;
          tx_sr <= {is_write, reg_addr,
                    is_write ? wdata : 32'h0};
          rx_sr <= '0;
        end
      end else begin
        if ((state_nxt != state) ||
            (shifting && half_end))
          cnt <= '0;
        else
          cnt <= cnt + 1'b1;
        if (shifting && half_end)
          phase <= ~phase;
        if (bit_end) begin
          tx_sr <= {tx_sr[38:0], 1'b0};
          bcnt  <= last_bit ? 5'd31 : bcnt - 5'd1;
          if (state == DATA_SHIFT)
            rx_sr <= {rx_sr[30:0], sdi};
        end
        if ((state == CS_HOLD) &&
            (state_nxt == IDLE)) begin
          done <= 1'b1;
          if (!wr_q) rdata <= rx_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_register_master.sv
// Bench for spi_register_master: register-file responder model, vector
// table, back-to-back, reset-abort and randomized transactions.
module tb_spi_register_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_write = 1'b0;
  logic [6:0]  reg_addr = '0;
  logic [31:0] wdata = '0;
  logic        sdi = 1'b0;
  logic        busy, done, sck, cs_n, sdo;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_register_master #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .is_write(is_write), .reg_addr(reg_addr),
    .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .sck(sck), .cs_n(cs_n),
    .sdo(sdo), .sdi(sdi)
  );

  // responder: register file fed from what is seen on the wire
  logic [31:0] resp_regs [128];
  // reference: register file fed from what the bench asked for
  logic [31:0] ref_regs [128];
  logic [31:0] resp_word = '0;
  logic [31:0] exp_rd = '0;
  logic [39:0] cap = '0;
  logic        sck_p = 1'b0;
  logic        cs_p = 1'b1;
  bit          no_resp = 1'b0;
  int cyc = 0, rises = 0, falls = 0;
  int busy_cyc = 0, dones = 0, cs_falls = 0;
  int viol = 0, b2b = 0, last_done = -100;
  int since_sck = 100, since_cs = 100;
  int t;

  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cyc++;
    if (done) begin
      dones++;
      last_done = cyc;
    end
    if (cs_n != cs_p) begin
      if (!reset && since_sck < 4) viol++;
      if (!cs_n) begin
        cs_falls++;
        rises = 0;
        falls = 0;
        b2b = cyc - last_done;
      end else if (!reset && rises == 40 && cap[39] &&
                   cap[38:32] != 7'h7F)
        resp_regs[cap[38:32]] = cap[31:0];
      since_cs = 0;
    end
    if (sck != sck_p) begin
      if (!reset) begin
        if (cs_n || since_cs < 4) viol++;
        if (sck && since_sck < 4) viol++;
        if (!sck && since_sck != 4) viol++;
      end
      if (sck) begin
        rises++;
        cap = {cap[38:0], sdo};
        if (rises == 8)
          resp_word = (cap[6:0] == 7'h7F) ?
                      32'hC001CAFE : resp_regs[cap[6:0]];
      end else begin
        falls++;
      end
      since_sck = 0;
    end
    if (no_resp)
      sdi = 1'b1;
    else if (!cs_n && falls >= 8 && falls < 40)
      sdi = resp_word[5'(39 - falls)];
    else
      sdi = 1'b0;
    cs_p = cs_n;
    sck_p = sck;
    since_sck++;
    since_cs++;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [6:0] a,
                     input logic [31:0] d,
                     input logic [7:0] ecmd,
                     input logic [31:0] erd,
                     input string nm);
    int n;
    @(posedge clk); #1;
    busy_cyc = 0;
    dones = 0;
    viol = 0;
    is_write = w;
    reg_addr = a;
    wdata = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (dones == 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done"}, 64'(dones), 64'd1);
    chk({nm, "_busy"}, 64'(busy_cyc), 64'd336);
    chk({nm, "_rises"}, 64'(rises), 64'd40);
    chk({nm, "_sdo"}, 64'(cap),
        64'({ecmd, w ? d : 32'h0}));
    chk({nm, "_rdata"}, 64'(rdata), 64'(erd));
    chk({nm, "_timing"}, 64'(viol), 64'd0);
  endtask

  typedef struct packed {
    logic        w;
    logic [6:0]  a;
    logic [31:0] d;
    logic        nores;
    logic [7:0]  ecmd;
    logic [31:0] erd;
  } vec_t;

  vec_t tv [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    logic [31:0] d;
    logic w;
    int sel;

    tv[0] = '{w: 1'b1, a: 7'd2, d: 32'h5, nores: 1'b0,
              ecmd: 8'h82, erd: 32'h0};
    tv[1] = '{w: 1'b0, a: 7'h7F, d: 32'h0, nores: 1'b0,
              ecmd: 8'h7F, erd: 32'hC001CAFE};
    tv[2] = '{w: 1'b1, a: 7'd4, d: 32'hDEADBEEF,
              nores: 1'b0, ecmd: 8'h84,
              erd: 32'hC001CAFE};
    tv[3] = '{w: 1'b0, a: 7'd4, d: 32'h0, nores: 1'b0,
              ecmd: 8'h04, erd: 32'hDEADBEEF};
    tv[4] = '{w: 1'b0, a: 7'd2, d: 32'hFFFF0000,
              nores: 1'b0, ecmd: 8'h02, erd: 32'h5};
    tv[5] = '{w: 1'b0, a: 7'd3, d: 32'h0, nores: 1'b1,
              ecmd: 8'h03, erd: 32'hFFFFFFFF};

    for (int i = 0; i < 128; i++) begin
      resp_regs[i] = '0;
      ref_regs[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 64'(cs_n), 64'd1);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      no_resp = tv[i].nores;
      txn(tv[i].w, tv[i].a, tv[i].d, tv[i].ecmd,
          tv[i].erd, $sformatf("vec%0d", i));
      if (tv[i].w) ref_regs[tv[i].a] = tv[i].d;
      exp_rd = tv[i].erd;
    end
    no_resp = 1'b0;

    // start held high: exactly two transactions, back to back
    @(posedge clk); #1;
    busy_cyc = 0;
    dones = 0;
    cs_falls = 0;
    viol = 0;
    is_write = 1'b1;
    reg_addr = 7'd5;
    wdata = 32'h12345678;
    start = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (dones < 2 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_dones", 64'(dones), 64'd2);
    chk("b2b_cs_falls", 64'(cs_falls), 64'd2);
    chk("b2b_gap", 64'(b2b), 64'd1);
    chk("b2b_busy", 64'(busy_cyc), 64'd672);
    chk("b2b_timing", 64'(viol), 64'd0);
    ref_regs[5] = 32'h12345678;

    // reset in the middle of a write
    @(posedge clk); #1;
    dones = 0;
    is_write = 1'b1;
    reg_addr = 7'd9;
    wdata = 32'hA5A55A5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (98) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_cs_n", 64'(cs_n), 64'd1);
    chk("abort_sck", 64'(sck), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    exp_rd = ref_regs[9];
    txn(1'b0, 7'd9, 32'h0, 8'h09, exp_rd, "after_abort");

    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 8);
      a = (sel == 8) ? 7'h7F : 7'(sel);
      d = $urandom;
      if (!w)
        exp_rd = (a == 7'h7F) ? 32'hC001CAFE : ref_regs[a];
      txn(w, a, d, {w, a}, exp_rd,
          $sformatf("rnd%0d", i));
      if (w && a != 7'h7F) ref_regs[a] = d;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
